// File: rtl/correlation_sequencer.sv
// Time-multiplexed 10-tap correlator: one multiply-accumulate unit walks the taps
// for each accepted sample and returns the result over a valid/ready port.
module correlation_sequencer #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_err,
  output logic              busy
);

  localparam int K_W = $clog2(TAPS);
  localparam logic [K_W-1:0] LAST_K = K_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;
  logic [DATA_W-1:0] win_q [TAPS];
  logic [DATA_W-1:0] win_d [TAPS];
  logic [DATA_W-1:0] coef_q [TAPS];
  logic [DATA_W-1:0] coef_d [TAPS];
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;
    win_d       = win_q;
    coef_d      = coef_q;
    prod        = {{DATA_W{1'b0}}, win_q[k_q]} * {{DATA_W{1'b0}}, coef_q[k_q]};

    // Writes land on the same edge as a sample acceptance, so that MAC sees them.
    if (cfg_we) begin
      if (state_q == IDLE && cfg_addr <= 4'(LAST_K)) begin
        coef_d[cfg_addr] = cfg_data;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (clear) begin
      state_d     = IDLE;
      k_d         = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      for (int i = 0; i < TAPS; i++) win_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            win_d[0] = in_data;
            for (int i = 1; i < TAPS; i++) win_d[i] = win_q[i-1];
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          acc_d = acc_q + {{(ACC_W-2*DATA_W){1'b0}}, prod};
          if (k_q == LAST_K) begin
            out_d       = acc_d;
            out_valid_d = 1'b1;
            k_d         = '0;
            state_d     = DONE;
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        win_q[i]  <= '0;
        coef_q[i] <= DATA_W'(i + 1);
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
      win_q       <= win_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_correlation_sequencer.sv
// Self-checking bench for correlation_sequencer: directed corner cases plus random
// samples and coefficient writes, compared against a sum-of-products model.
module tb_correlation_sequencer;

  logic        clock = 1'b0;
  logic        reset, clear, in_valid, out_ready, cfg_we;
  logic [3:0]  in_data, cfg_addr, cfg_data;
  logic        in_ready, out_valid, cfg_err, busy;
  logic [11:0] out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acceptCyc = 0;
  int lastResult = 0;
  int modelH [10];
  int modelX [10];

  correlation_sequencer dut (
    .clock(clock), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // The model is just the correlation formula over a plain sample/coefficient list.
  function automatic void modelReset();
    for (int i = 0; i < 10; i++) begin
      modelH[i] = i + 1;
      modelX[i] = 0;
    end
  endfunction

  function automatic void modelShift(input int d);
    for (int i = 9; i > 0; i--) modelX[i] = modelX[i-1];
    modelX[0] = d;
  endfunction

  function automatic int modelOut();
    int s;
    s = 0;
    for (int i = 0; i < 10; i++) s += modelX[i] * modelH[i];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int d);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    checkOutput("ready_wait", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 4'(d);
    tick();
    in_valid  = 1'b0;
    acceptCyc = cyc;
    modelShift(d);
  endtask

  // Waits for the result, checks latency/value, applies backpressure, then accepts it.
  task automatic awaitResult(input int hold, input int constExpect);
    int n;
    int held;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("valid_wait", int'(out_valid), 1);
    checkOutput("latency", cyc - acceptCyc, 10);
    checkOutput("result", int'(out), modelOut());
    if (constExpect >= 0) checkOutput("result_const", int'(out), constExpect);
    lastResult = modelOut();
    held = int'(out);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_valid", int'(out_valid), 1);
      checkOutput("hold_out", int'(out), held);
      checkOutput("hold_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("release_valid", int'(out_valid), 0);
    checkOutput("release_ready", int'(in_ready), 1);
  endtask

  task automatic doWrite(input int addr, input int data, input bit busyNow);
    int expErr;
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = 4'(data);
    tick();
    cfg_we = 1'b0;
    expErr = (busyNow || addr >= 10) ? 1 : 0;
    checkOutput("cfg_err", int'(cfg_err), expErr);
    if (expErr == 0) modelH[addr] = data;
    tick();
    checkOutput("cfg_err_pulse", int'(cfg_err), 0);
  endtask

  task automatic runThroughput();
    int q[$];
    int lastAcc;
    int n;
    int exp;
    lastAcc   = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : -1;
        checkOutput("tp_result", int'(out), exp);
      end
      in_data = 4'($urandom_range(0, 15));
      if (in_ready) begin
        modelShift(int'(in_data));
        q.push_back(modelOut());
        if (lastAcc >= 0) checkOutput("tp_gap", cyc - lastAcc, 12);
        lastAcc = cyc;
      end
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 30) begin
      if (out_valid) begin
        exp = q.pop_front();
        checkOutput("tp_result", int'(out), exp);
      end
      tick();
      n++;
    end
    checkOutput("tp_drained", q.size(), 0);
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    in_data = '0; cfg_addr = '0; cfg_data = '0;
    modelReset();
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out", int'(out), 0);
    checkOutput("rst_cfg_err", int'(cfg_err), 0);

    // Default coefficients: ten samples of 15 build up to 825.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(15);
      if (i == 0) begin
        tick();
        checkOutput("mac_busy", int'(busy), 1);
        checkOutput("mac_in_ready", int'(in_ready), 0);
      end
      awaitResult((i == 3) ? 5 : 0, (i == 0) ? 15 : ((i == 9) ? 825 : -1));
    end

    applyStimulus(3);
    tick();
    doWrite(0, 9, 1'b1);
    awaitResult(0, -1);
    doWrite(12, 5, 1'b0);

    applyStimulus(5);
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) modelX[i] = 0;
    checkOutput("clear_busy", int'(busy), 0);
    checkOutput("clear_valid", int'(out_valid), 0);
    checkOutput("clear_out_kept", int'(out), lastResult);
    repeat (12) tick();
    checkOutput("clear_no_valid", int'(out_valid), 0);
    applyStimulus(7);
    awaitResult(0, 7);

    for (int i = 0; i < 10; i++) doWrite(i, 15, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(15);
      awaitResult(0, (i == 9) ? 2250 : -1);
    end

    // Write and sample in the same IDLE cycle: the new coefficient must be used.
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 4'd6;
    in_valid = 1'b1; in_data = 4'd11;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    acceptCyc = cyc;
    modelH[2] = 6;
    modelShift(11);
    checkOutput("same_cycle_err", int'(cfg_err), 0);
    awaitResult(2, -1);

    runThroughput();

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1)
        doWrite(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
      applyStimulus(int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        tick();
        doWrite(int'($urandom_range(0, 9)), int'($urandom_range(0, 15)), 1'b1);
      end
      awaitResult(int'($urandom_range(0, 3)), -1);
    end

    // Asynchronous reset in the middle of a MAC run.
    applyStimulus(9);
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_out", int'(out), 0);
    checkOutput("arst_valid", int'(out_valid), 0);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_in_ready", int'(in_ready), 1);
    checkOutput("arst_cfg_err", int'(cfg_err), 0);
    reset = 1'b0;
    modelReset();
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(15);
      awaitResult(0, (i == 9) ? 825 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/correlation_sequencer.md
# correlation_sequencer

Time-multiplexed controller for the 10-tap, 4-bit correlation datapath. Replaces the fully parallel 10-multiplier correlator with a single multiply-accumulate (MAC) unit that the block sequences over the taps. The block holds a programmable coefficient bank and a 10-deep sample window. It accepts one sample per handshake and returns one 12-bit correlation result per sample over a valid/ready output. It sits between the sample source and any consumer of correlation results.

## Interface
- TAPS, 10, number of taps, which is also the window depth
- DATA_W, 4, sample and coefficient width (unsigned)
- ACC_W, 12, result width; 10·15·15 = 2250 < 4096, so the result never overflows

- clock  in  1  rising-edge clock; the only clock in the block
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous: aborts any operation and zeroes the window; coefficients are kept
- in_valid  in  1  sample offered
- in_data  in  DATA_W  sample value
- in_ready  out  1  block can accept a sample; high only in IDLE
- out_valid  out  1  result available; held until accepted
- out_ready  in  1  consumer accepts the result
- out  out  ACC_W  correlation result; holds its value between results
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  4  coefficient index
- cfg_data  in  DATA_W  coefficient value
- cfg_err  out  1  one-cycle pulse when a write is rejected
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Correlation definition: out = Σ x_k·h_k for k = 0..9, where x_0 is the newest sample.
- Coefficient reset values: h_k = k+1, giving 1..10.
- Window reset value: all x_k = 0.
- **FSM states:** IDLE, MAC, DONE.
- **IDLE:**
  - in_ready = 1.
  - When in_valid is high: shift the window (x_k ← x_{k-1}, x_0 ← in_data), set k = 0, set acc = 0, go to MAC.
- **MAC:**
  - Each cycle: acc ← acc + x_k·h_k, then k ← k+1.
  - After k = 9 is processed: out ← final acc, go to DONE.
  - Products are 8 bits; the accumulator is ACC_W bits, zero-extended.
- **DONE:**
  - out_valid = 1.
  - When out_ready is high: go to IDLE.
- **Coefficient writes:**
  - A write is applied only when state = IDLE and cfg_addr < TAPS: h[cfg_addr] ← cfg_data on that edge.
  - Any write attempted while busy, or with cfg_addr ≥ TAPS, is dropped and cfg_err pulses for one cycle.
- **cfg_we and in_valid in the same IDLE cycle:** both take effect. The sample's MAC uses the newly written coefficient.
- **clear:**
  - Highest priority after reset.
  - Next state is IDLE; the window is zeroed; acc and k are zeroed; out_valid drops.
  - out keeps its last value.
  - A pending in_valid in the same cycle is not accepted.
- **Reset values:** state = IDLE, out = 0, out_valid = 0, cfg_err = 0, busy = 0, in_ready = 1 (combinational from state), window = 0, coefficients = 1..10.
- **Reset mid-operation:** all of the above applies immediately; the partial result is discarded.

## Timing
- **Acceptance edge E0:** the edge where in_valid & in_ready.
- **MAC edges:** the MAC runs on edges E1..E10. out and out_valid are visible after E10, so latency is 10 cycles.
- **Return to IDLE:** on the edge where out_valid & out_ready; in_ready rises in the following cycle.
- **Throughput:** with out_ready tied high, one sample is accepted every 12 cycles.
- **Backpressure:** while out_ready is low, out_valid and out are held stable and in_ready stays 0. No sample is lost and none is accepted.
- **cfg_err:** asserted in the cycle after the rejected write edge, for exactly one cycle.
- **Write visibility:** a write applied at edge E is visible to every MAC that starts at or after E.

## Test plan
- **Default coefficients, single sample:** after reset, send sample 15 → out = 15, out_valid high 10 cycles after acceptance.
- **Default coefficients, full window:** send ten samples of 15 → results 15, 45, 90, … ; the 10th result = 825.
- **Maximum result:** write every h_k = 15 in IDLE, then send ten samples of 15 → 10th result = 2250, with no wrap.
- **Rejected writes:**
  - Write during MAC → cfg_err pulses for 1 cycle and the coefficient is unchanged; verify via a subsequent result.
  - Write with cfg_addr = 12 in IDLE → cfg_err pulses and no coefficient changes.
- **Backpressure:** hold out_ready low for 5 cycles in DONE → out_valid and out are stable and in_ready = 0; raise out_ready → IDLE one cycle later.
- **clear and reset mid-operation:**
  - Assert clear at MAC k = 4 → IDLE next cycle with no out_valid; then send sample 7 → out = 7.
  - Assert reset asynchronously mid-MAC → all outputs go to their reset values and coefficients return to 1..10.
